// File: rtl/synth1_spi_tx.sv
// Host-side serial transmitter for the synth1 control port: MSB first, sck idles high,
// sdi changes on sck rising edges so the receiver can sample on falling edges.
module synth1_spi_tx #(
   parameter int unsigned WORD_W  = 16,
   parameter int unsigned CLK_DIV = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              word_done,
   output logic              busy,
   output logic              ss_n,
   output logic              sck,
   output logic              sdi
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W = $clog2(WORD_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t            state, state_nxt;
   logic [DIV_W-1:0]  div_cnt, div_nxt;
   logic [WORD_W-1:0] shreg, shreg_nxt, shifted;
   logic [BIT_W-1:0]  bit_cnt, bit_nxt;
   logic              sck_nxt, sdi_nxt, ss_n_nxt, done_nxt, ready_nxt, busy_nxt;
   logic              tick, accept, fall, rise;

   assign tick    = (div_cnt == DIV_LAST);
   assign accept  = tx_valid && tx_ready;
   assign fall    = tick && ((state == SETUP) || ((state == SHIFT) && sck));
   assign rise    = tick && (state == SHIFT) && !sck;
   assign shifted = shreg << 1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         div_cnt   <= '0;
         shreg     <= '0;
         bit_cnt   <= '0;
         sck       <= 1'b1;
         sdi       <= 1'b0;
         ss_n      <= 1'b1;
         word_done <= 1'b0;
         tx_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= div_nxt;
         shreg     <= shreg_nxt;
         bit_cnt   <= bit_nxt;
         sck       <= sck_nxt;
         sdi       <= sdi_nxt;
         ss_n      <= ss_n_nxt;
         word_done <= done_nxt;
         tx_ready  <= ready_nxt;
         busy      <= busy_nxt;
      end
   end

   // The end-of-word cycle is marked by the registered word_done; SHIFT decides there
   // whether to stream the next word or wind down through HOLD.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   if (tick) state_nxt = SHIFT;
         SHIFT:   if (word_done && !accept) state_nxt = HOLD;
         HOLD:    if (tick) state_nxt = GAP;
         GAP:     if (tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      div_nxt   = (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
      shreg_nxt = shreg;
      bit_nxt   = bit_cnt;
      sck_nxt   = sck;
      sdi_nxt   = sdi;
      case (state)
         IDLE: begin
            sck_nxt = 1'b1;
            sdi_nxt = 1'b0;
            bit_nxt = '0;
            if (accept) begin
               shreg_nxt = tx_data;
               sdi_nxt   = tx_data[WORD_W-1];
            end
         end
         SETUP, SHIFT: begin
            // Streaming reload keeps div_cnt running so the sck period stays unbroken.
            if (word_done) begin
               if (accept) begin
                  shreg_nxt = tx_data;
                  sdi_nxt   = tx_data[WORD_W-1];
                  bit_nxt   = '0;
               end else begin
                  sdi_nxt = 1'b0;
               end
            end
            if (fall) begin
               sck_nxt = 1'b0;
               bit_nxt = bit_cnt + 1'b1;
            end else if (rise) begin
               sck_nxt = 1'b1;
               if (bit_cnt != BIT_LAST) begin
                  shreg_nxt = shifted;
                  sdi_nxt   = shifted[WORD_W-1];
               end
            end
         end
         default: begin
            sck_nxt = 1'b1;
            sdi_nxt = 1'b0;
         end
      endcase
      done_nxt  = rise && (bit_cnt == BIT_LAST);
      ss_n_nxt  = !(state_nxt inside {SETUP, SHIFT, HOLD});
      busy_nxt  = (state_nxt != IDLE);
      ready_nxt = (state_nxt == IDLE) || done_nxt;
   end

endmodule

// File: tb/tb_synth1_spi_tx.sv
// Bench for synth1_spi_tx: two instances (CLK_DIV 5 and 2) observed by a falling-edge
// receiver model, with event timing compared against closed-form cycle formulas.
module tb_synth1_spi_tx;

   localparam int W  = 16;
   localparam int NE = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset     [2];
   logic [W-1:0] tx_data   [2];
   logic         tx_valid  [2];
   logic         tx_ready  [2];
   logic         word_done [2];
   logic         busy      [2];
   logic         ss_n      [2];
   logic         sck       [2];
   logic         sdi       [2];

   synth1_spi_tx #(.WORD_W(W), .CLK_DIV(5)) u_dut0 (
      .clk(clk), .reset(reset[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .word_done(word_done[0]), .busy(busy[0]),
      .ss_n(ss_n[0]), .sck(sck[0]), .sdi(sdi[0])
   );

   synth1_spi_tx #(.WORD_W(W), .CLK_DIV(2)) u_dut1 (
      .clk(clk), .reset(reset[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .word_done(word_done[1]), .busy(busy[1]),
      .ss_n(ss_n[1]), .sck(sck[1]), .sdi(sdi[1])
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int dv(input int g);
      return (g == 0) ? 5 : 2;
   endfunction

   // receiver / event recorder state
   logic [W-1:0] got_w  [2][NE];
   int           done_t [2][NE];
   int           ssf_t  [2][NE];
   int           ssr_t  [2][NE];
   int           rdy_t  [2][NE];
   int           n_got [2], n_done [2], n_ssf [2], n_ssr [2], n_rdy [2], falls [2];
   int           last_edge [2], nbits [2];
   logic [W-1:0] bits [2];
   logic         p_ss [2], p_sck [2], p_sdi [2], p_rdy [2];
   bit           mon_en = 1'b0;

   initial begin
      for (int g = 0; g < 2; g++) begin
         n_got[g] = 0; n_done[g] = 0; n_ssf[g] = 0; n_ssr[g] = 0; n_rdy[g] = 0;
         falls[g] = 0; last_edge[g] = 0; nbits[g] = 0; bits[g] = '0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (mon_en) begin
               if (!ss_n[g] && p_ss[g]) begin
                  last_edge[g] = cyc;
                  nbits[g] = 0;
                  if (n_ssf[g] < NE) ssf_t[g][n_ssf[g]] = cyc;
                  n_ssf[g]++;
               end
               if (ss_n[g] && !p_ss[g]) begin
                  if (n_ssr[g] < NE) ssr_t[g][n_ssr[g]] = cyc;
                  n_ssr[g]++;
               end
               if (!ss_n[g] && (sck[g] != p_sck[g])) begin
                  check($sformatf("ch%0d_half_period", g), 64'(cyc - last_edge[g]), 64'(dv(g)));
                  last_edge[g] = cyc;
                  if (!sck[g]) begin
                     bits[g] = {bits[g][W-2:0], p_sdi[g]};
                     nbits[g]++;
                     falls[g]++;
                     if (nbits[g] == W) begin
                        if (n_got[g] < NE) got_w[g][n_got[g]] = bits[g];
                        n_got[g]++;
                        nbits[g] = 0;
                     end
                  end
               end
               if (word_done[g]) begin
                  if (n_done[g] < NE) done_t[g][n_done[g]] = cyc;
                  n_done[g]++;
               end
               if (tx_ready[g] && !p_rdy[g]) begin
                  if (n_rdy[g] < NE) rdy_t[g][n_rdy[g]] = cyc;
                  n_rdy[g]++;
               end
            end
            p_ss[g]  = ss_n[g];
            p_sck[g] = sck[g];
            p_sdi[g] = sdi[g];
            p_rdy[g] = tx_ready[g];
         end
      end
   end

   logic [W-1:0] sw [8];

   // Offers sw[0..n-1] starting at this negedge with the block idle. Word 0 is offered at
   // t=0; later words are held valid from t=late with junk data except on the cycles where
   // the model says the block is ready (t = 1 + per*i).
   task automatic run_stream(input int g, input int n, input int late);
      int d, per, base, last_acc, tend, k;
      int s_got, s_done, s_ssf, s_ssr, s_rdy, s_falls;
      d        = dv(g);
      per      = 2 * W * d;
      last_acc = (n == 1) ? 0 : 1 + per * (n - 1);
      tend     = 1 + per * n + 2 * d + 3;
      s_got = n_got[g]; s_done = n_done[g]; s_ssf = n_ssf[g];
      s_ssr = n_ssr[g]; s_rdy = n_rdy[g]; s_falls = falls[g];
      base = cyc;
      for (int t = 0; t <= tend; t++) begin
         k = -1;
         if (t == 0) k = 0;
         else if (t > 1 && ((t - 1) % per) == 0 && ((t - 1) / per) < n) k = (t - 1) / per;
         tx_valid[g] = (t == 0) || (t >= late && t <= last_acc);
         tx_data[g]  = (k >= 0) ? sw[k] : W'($urandom);
         @(negedge clk);
      end
      tx_valid[g] = 1'b0;
      check($sformatf("ch%0d_word_count", g), 64'(n_got[g] - s_got), 64'(n));
      check($sformatf("ch%0d_fall_count", g), 64'(falls[g] - s_falls), 64'(W * n));
      check($sformatf("ch%0d_done_count", g), 64'(n_done[g] - s_done), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (s_got + i < n_got[g])
            check($sformatf("ch%0d_word%0d", g, i), 64'(got_w[g][s_got + i]), 64'(sw[i]));
         if (s_done + i < n_done[g])
            check($sformatf("ch%0d_done_cyc%0d", g, i), 64'(done_t[g][s_done + i] - base),
                  64'(1 + per * (i + 1)));
      end
      check($sformatf("ch%0d_ss_fall_count", g), 64'(n_ssf[g] - s_ssf), 64'(1));
      if (n_ssf[g] > s_ssf)
         check($sformatf("ch%0d_ss_fall_cyc", g), 64'(ssf_t[g][s_ssf] - base), 64'(1));
      check($sformatf("ch%0d_ss_rise_count", g), 64'(n_ssr[g] - s_ssr), 64'(1));
      if (n_ssr[g] > s_ssr)
         check($sformatf("ch%0d_ss_rise_cyc", g), 64'(ssr_t[g][s_ssr] - base),
               64'(1 + per * n + d));
      check($sformatf("ch%0d_ready_rises", g), 64'(n_rdy[g] - s_rdy), 64'(n + 1));
      if (n_rdy[g] > s_rdy)
         check($sformatf("ch%0d_ready_cyc", g), 64'(rdy_t[g][n_rdy[g] - 1] - base),
               64'(1 + per * n + 2 * d));
   endtask

   task automatic check_idle_outputs(input string tag, input int g);
      check({tag, "_ss_n"},      64'(ss_n[g]),      64'(1));
      check({tag, "_sck"},       64'(sck[g]),       64'(1));
      check({tag, "_sdi"},       64'(sdi[g]),       64'(0));
      check({tag, "_tx_ready"},  64'(tx_ready[g]),  64'(1));
      check({tag, "_word_done"}, 64'(word_done[g]), 64'(0));
      check({tag, "_busy"},      64'(busy[g]),      64'(0));
   endtask

   int v_ss, v_sck, v_rdy, v_sdi, base, s_got, s_ssr, nw, gg;

   initial begin
      for (int g = 0; g < 2; g++) begin
         reset[g] = 1'b1; tx_valid[g] = 1'b0; tx_data[g] = '0;
      end
      repeat (3) @(negedge clk);
      check_idle_outputs("rst0", 0);
      check_idle_outputs("rst1", 1);
      reset[0] = 1'b0; reset[1] = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // idle with junk data
      v_ss = 0; v_sck = 0; v_rdy = 0; v_sdi = 0;
      for (int c = 0; c < 500; c++) begin
         tx_data[0] = W'($urandom);
         @(negedge clk);
         if (ss_n[0] !== 1'b1) v_ss++;
         if (sck[0] !== 1'b1) v_sck++;
         if (tx_ready[0] !== 1'b1) v_rdy++;
         if (sdi[0] !== 1'b0) v_sdi++;
      end
      check("idle_ss_n_changes", 64'(v_ss), 64'(0));
      check("idle_sck_changes", 64'(v_sck), 64'(0));
      check("idle_ready_changes", 64'(v_rdy), 64'(0));
      check("idle_sdi_changes", 64'(v_sdi), 64'(0));

      sw[0] = 16'h01AB;
      run_stream(0, 1, 1);

      sw[0] = 16'h01AB; sw[1] = 16'hFFFF; sw[2] = 16'h8001;
      run_stream(0, 3, 1);

      sw[0] = W'($urandom); sw[1] = 16'h1234;
      run_stream(0, 2, 50);

      // reset mid-word at cycle 80
      s_got = n_got[0]; s_ssr = n_ssr[0];
      base = cyc;
      tx_valid[0] = 1'b1; tx_data[0] = W'($urandom);
      @(negedge clk);
      tx_valid[0] = 1'b0;
      repeat (79) @(negedge clk);
      reset[0] = 1'b1; tx_valid[0] = 1'b1; tx_data[0] = W'($urandom);
      @(negedge clk);
      reset[0] = 1'b0; tx_valid[0] = 1'b0;
      check_idle_outputs("abort", 0);
      check("abort_no_capture", 64'(n_got[0] - s_got), 64'(0));
      if (n_ssr[0] > s_ssr)
         check("abort_ss_rise_cyc", 64'(ssr_t[0][s_ssr] - base), 64'(81));
      else
         check("abort_ss_rise_count", 64'(n_ssr[0] - s_ssr), 64'(1));
      @(negedge clk);
      sw[0] = 16'h00FF;
      run_stream(0, 1, 1);

      // reset wins over an accept on the same cycle
      reset[0] = 1'b1; tx_valid[0] = 1'b1; tx_data[0] = W'($urandom);
      @(negedge clk);
      reset[0] = 1'b0; tx_valid[0] = 1'b0;
      check_idle_outputs("rst_accept", 0);
      @(negedge clk);

      sw[0] = 16'h8000; sw[1] = 16'h0001; sw[2] = 16'hAAAA;
      run_stream(1, 3, 1);
      sw[0] = 16'h0001;
      run_stream(1, 1, 1);

      for (int r = 0; r < 6; r++) begin
         gg = r % 2;
         nw = $urandom_range(1, 3);
         for (int i = 0; i < nw; i++) sw[i] = W'($urandom);
         run_stream(gg, nw, $urandom_range(1, 2 * W * dv(gg) - 2));
         repeat ($urandom_range(0, 7)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/synth1_spi_tx.md
# synth1_spi_tx

Serial control-word transmitter that drives the synth1 control port (`ss_n`, `sck`, `sdi`) from a parallel word handshake. It is the host-side counterpart of the synth1 serial receiver. It is used as the on-chip controller in integrated builds and as the synthesizable stimulus source in the synth1 benches. Words go out MSB first. `sck` idles high, `sdi` changes on the `sck` rising edge, and the receiver samples on the `sck` falling edge.

## Interface
- `WORD_W`, 16: bits per control word.
- `CLK_DIV`, 5: `clk` cycles per `sck` half-period; legal range is 2 to 255.
- `clk` in 1: system clock; every output is registered on its rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `tx_data` in `WORD_W`: word to send; captured on the accept cycle.
- `tx_valid` in 1: a word is offered.
- `tx_ready` out 1: the block accepts `tx_data` this cycle; the accept cycle is `tx_valid && tx_ready`.
- `word_done` out 1: one-cycle pulse when the last bit of a word has been clocked out.
- `busy` out 1: high whenever the state is not IDLE.
- `ss_n` out 1: slave select, active low.
- `sck` out 1: serial clock, idles high.
- `sdi` out 1: serial data to synth1.

## Operation
- States:
  - IDLE: `ss_n`=1, `sck`=1, `sdi`=0.
  - SETUP: `ss_n`=0, `sck`=1, `sdi` = MSB.
  - SHIFT: `sck` toggles.
  - HOLD: `ss_n`=0, `sck`=1.
  - GAP: `ss_n`=1, `sck`=1.
- Internal: half-period counter `div_cnt` (0..`CLK_DIV`-1; tick when it equals `CLK_DIV`-1), a `WORD_W` shift register, and a bit counter.
- Transitions:
  - IDLE -> SETUP on accept: load the shift register, `sdi` = `tx_data[WORD_W-1]`, `ss_n` goes to 0.
  - SETUP -> SHIFT on tick: `sck` goes to 0. This is the falling edge that samples the MSB.
  - SHIFT, on each tick: toggle `sck`. On a rising tick with bits remaining, shift left and present the next bit on `sdi`.
  - SHIFT, on the rising tick after the `WORD_W`-th falling edge: end of word. `word_done`=1 for that cycle and `tx_ready`=1 for that cycle.
    - If `tx_valid`=1 on that cycle: load the new word, drive `sdi` = new MSB, keep `ss_n` at 0, and stay in SHIFT. This gives a back-to-back stream with no select gap and an unbroken `sck` period.
    - Otherwise: go to HOLD and drive `sdi` to 0.
  - HOLD -> GAP on tick: `ss_n` goes to 1.
  - GAP -> IDLE on tick.
- `tx_ready` is decoded from registered state only. It is high in IDLE and on the end-of-word cycle, and low everywhere else. There is no combinational path from `tx_valid`.
- When `tx_valid` is high while `tx_ready` is low, the block ignores it. `tx_data` is don't-care outside the accept cycle.
- `reset` overrides every other input, including an accept on the same cycle.

## Timing
- Reset values, on the cycle after `reset` is sampled high: state IDLE, `ss_n`=1, `sck`=1, `sdi`=0, `tx_ready`=1, `word_done`=0, `busy`=0, all counters 0.
- Reset mid-word aborts immediately. `ss_n` returns to 1 with no HOLD phase, and the partial word is never resumed.
- Cycle timeline for a single word, with the accept at cycle 0 and times in cycles after that edge:
  - `ss_n`=0 and MSB on `sdi` at cycle 1.
  - Falling edge k (k = 1..`WORD_W`) at 1 + (2k-1)·`CLK_DIV`.
  - `sdi` is stable for `CLK_DIV` cycles on each side of every falling edge.
  - End-of-word rising edge and `word_done` at 1 + 2·`WORD_W`·`CLK_DIV`.
  - `ss_n`=1 at 1 + (2·`WORD_W`+1)·`CLK_DIV`.
  - `tx_ready` high again at 1 + (2·`WORD_W`+2)·`CLK_DIV`.
- With defaults (`WORD_W`=16, `CLK_DIV`=5): `ss_n` falls at cycle 1, the first falling edge is at cycle 6, the last falling edge at cycle 156, `word_done` at cycle 161, `ss_n` rises at cycle 166, and the block is ready at cycle 171.
- Back-to-back words: the word period is exactly 2·`WORD_W`·`CLK_DIV` cycles. The new MSB appears on the same cycle as the end-of-word rising edge.
- Duty cycle: `sck` high and low phases are each exactly `CLK_DIV` cycles throughout SHIFT.

## Test plan
- Single word, defaults: send `tx_data`=0x01AB.
  - Required: a receiver model sampling `sdi` on `sck` falling edges captures 0x01AB.
  - Required: exactly 16 falling edges while `ss_n`=0.
  - Required: `word_done` at cycle 161, `ss_n` rises at cycle 166, `tx_ready` at cycle 171.
- Back-to-back: hold `tx_valid` high with words 0x01AB, 0xFFFF, 0x8001.
  - Required: `ss_n` stays 0 across all three words.
  - Required: three `word_done` pulses spaced 160 cycles apart.
  - Required: the receiver captures all three words in order, and no `sck` half-period differs from 5 cycles.
- Handshake: raise `tx_valid` with 0x1234 at cycle 50 of an in-flight word.
  - Required: not accepted until the end-of-word cycle, then 0x1234 is sent.
  - Required: changing `tx_data` while `tx_ready`=0 has no effect.
- Reset mid-word: assert `reset` for 1 cycle at cycle 80 of a word.
  - Required: on the next cycle `ss_n`=1, `sck`=1, `sdi`=0, `tx_ready`=1, `busy`=0.
  - Required: a new word 0x00FF then transmits cleanly.
- Bit-edge patterns: send 0x8000, 0x0001 and 0xAAAA with `CLK_DIV`=2.
  - Required: captures are exact, with a word period of 64 cycles when streamed.
- Idle: hold `tx_valid`=0 for 500 cycles.
  - Required: `ss_n`, `sck` and `tx_ready` stay constant at 1, and `sdi` stays 0.
